// File: rtl/ks_data_path_p.sv
// K&S processor datapath: instruction register, program counter, register file,
// ALU, flags register and RAM address mux, driven by the external control unit.
package ks_data_path_p_pkg;
  typedef enum logic [4:0] {
    I_NOP, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR, I_XOR,
    I_BRANCH, I_BZERO, I_BNEG, I_BOV, I_BNOV, I_BNNEG, I_BNZERO, I_HALT
  } instr_t;
endpackage

module ks_data_path_p
  import ks_data_path_p_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_REGS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branch,
  input  logic              pc_enable,
  input  logic              ir_enable,
  input  logic              addr_sel,
  input  logic              c_sel,
  input  logic [2:0]        operation,
  input  logic              write_reg_enable,
  input  logic              flags_reg_enable,
  output instr_t            decoded_instruction,
  output logic              illegal_instr,
  output logic              zero_op,
  output logic              neg_op,
  output logic              unsigned_overflow,
  output logic              signed_overflow,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] data_out,
  input  logic [DATA_W-1:0] data_in
);

  localparam int unsigned RW = $clog2(NUM_REGS);

  logic [DATA_W-1:0] ir;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] regs [NUM_REGS];

  logic [7:0]        opcode;
  logic [ADDR_W-1:0] mem_field;
  logic [ADDR_W-1:0] mem_addr;
  logic [RW-1:0]     f0, f1, f2, fl;
  logic [RW-1:0]     a_addr, b_addr, c_addr;

  logic [DATA_W-1:0] bus_a, bus_b, bus_c;
  logic [DATA_W-1:0] alu_out;
  logic [DATA_W-1:0] b_in;
  logic [DATA_W:0]   sum;
  logic              alu_uo, alu_so;
  logic              unused_ir_bits;

  assign opcode    = ir[DATA_W-1 -: 8];
  assign mem_field = ir[ADDR_W-1:0];
  assign f0        = ir[RW-1:0];
  assign f1        = ir[2*RW-1:RW];
  assign f2        = ir[3*RW-1:2*RW];
  assign fl        = ir[ADDR_W+RW-1:ADDR_W];
  assign unused_ir_bits = ^ir;

  // Instruction decode; unused register addresses and mem_addr stay at zero
  always_comb begin
    decoded_instruction = I_NOP;
    illegal_instr       = 1'b0;
    a_addr              = '0;
    b_addr              = '0;
    c_addr              = '0;
    mem_addr            = '0;
    case (opcode)
      8'h00: decoded_instruction = I_NOP;
      8'h81: begin decoded_instruction = I_LOAD;  c_addr = fl; mem_addr = mem_field; end
      8'h82: begin decoded_instruction = I_STORE; a_addr = fl; mem_addr = mem_field; end
      8'h91: begin decoded_instruction = I_MOVE;  a_addr = f0; b_addr = f0; c_addr = f1; end
      8'hA1: begin decoded_instruction = I_ADD; a_addr = f0; b_addr = f1; c_addr = f2; end
      8'hA2: begin decoded_instruction = I_SUB; a_addr = f0; b_addr = f1; c_addr = f2; end
      8'hA3: begin decoded_instruction = I_AND; a_addr = f0; b_addr = f1; c_addr = f2; end
      8'hA4: begin decoded_instruction = I_OR;  a_addr = f0; b_addr = f1; c_addr = f2; end
      8'hA5: begin decoded_instruction = I_XOR; a_addr = f0; b_addr = f1; c_addr = f2; end
      8'h01: begin decoded_instruction = I_BRANCH; mem_addr = mem_field; end
      8'h02: begin decoded_instruction = I_BZERO;  mem_addr = mem_field; end
      8'h03: begin decoded_instruction = I_BNEG;   mem_addr = mem_field; end
      8'h05: begin decoded_instruction = I_BOV;    mem_addr = mem_field; end
      8'h06: begin decoded_instruction = I_BNOV;   mem_addr = mem_field; end
      8'h0A: begin decoded_instruction = I_BNNEG;  mem_addr = mem_field; end
      8'h0B: begin decoded_instruction = I_BNZERO; mem_addr = mem_field; end
      8'hFF: decoded_instruction = I_HALT;
      default: illegal_instr = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            ir <= '0;
    else if (ir_enable) ir <= data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            pc <= '0;
    else if (pc_enable) pc <= branch ? mem_addr : pc + ADDR_W'(1);
  end

  assign ram_addr = addr_sel ? mem_addr : pc;

  assign bus_a    = regs[a_addr];
  assign bus_b    = regs[b_addr];
  assign data_out = bus_a;
  assign bus_c    = c_sel ? alu_out : data_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
    end else if (write_reg_enable) begin
      regs[c_addr] <= bus_c;
    end
  end

  // ALU; SUB reuses the adder as A + ~B + 1, so a missing carry-out is a borrow
  always_comb begin
    alu_out = bus_a;
    alu_uo  = 1'b0;
    alu_so  = 1'b0;
    b_in    = bus_b;
    sum     = '0;
    case (operation)
      3'b000: alu_out = bus_a | bus_b;
      3'b001, 3'b010: begin
        if (operation == 3'b010) begin
          b_in = ~bus_b;
          sum  = {1'b0, bus_a} + {1'b0, b_in} + (DATA_W+1)'(1);
        end else begin
          sum  = {1'b0, bus_a} + {1'b0, b_in};
        end
        alu_out = sum[DATA_W-1:0];
        alu_uo  = (operation == 3'b010) ? ~sum[DATA_W] : sum[DATA_W];
        // carry into the MSB recovered from the MSB sum bit and its operands
        alu_so  = (sum[DATA_W-1] ^ bus_a[DATA_W-1] ^ b_in[DATA_W-1]) ^ sum[DATA_W];
      end
      3'b011:  alu_out = bus_a & bus_b;
      3'b100:  alu_out = bus_a ^ bus_b;
      default: alu_out = bus_a;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_op           <= 1'b0;
      neg_op            <= 1'b0;
      unsigned_overflow <= 1'b0;
      signed_overflow   <= 1'b0;
    end else if (flags_reg_enable) begin
      zero_op           <= (alu_out == '0);
      neg_op            <= alu_out[DATA_W-1];
      unsigned_overflow <= alu_uo;
      signed_overflow   <= alu_so;
    end
  end

endmodule

// File: tb/tb_ks_data_path_p.sv
// Bench for ks_data_path_p: ALU vector table, randomized ALU traffic against an
// arithmetic model, control corner sequences, and a 32-bit/8-register instance.
module tb_ks_data_path_p;
  import ks_data_path_p_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, branch, pc_enable, ir_enable, addr_sel, c_sel;
  logic write_reg_enable, flags_reg_enable;
  logic [2:0] operation;

  logic [15:0] din16, do16;
  logic [4:0]  ra16;
  instr_t      dec16;
  logic        ill16, z16, n16, uo16, so16;

  logic [31:0] din32, do32;
  logic [7:0]  ra32;
  instr_t      dec32;
  logic        ill32, z32, n32, uo32, so32;

  int checks = 0;
  int fails  = 0;

  ks_data_path_p #(.DATA_W(16), .ADDR_W(5), .NUM_REGS(4)) dut16 (
    .clk(clk), .rst(rst), .branch(branch), .pc_enable(pc_enable),
    .ir_enable(ir_enable), .addr_sel(addr_sel), .c_sel(c_sel),
    .operation(operation), .write_reg_enable(write_reg_enable),
    .flags_reg_enable(flags_reg_enable), .decoded_instruction(dec16),
    .illegal_instr(ill16), .zero_op(z16), .neg_op(n16),
    .unsigned_overflow(uo16), .signed_overflow(so16), .ram_addr(ra16),
    .data_out(do16), .data_in(din16));

  ks_data_path_p #(.DATA_W(32), .ADDR_W(8), .NUM_REGS(8)) dut32 (
    .clk(clk), .rst(rst), .branch(branch), .pc_enable(pc_enable),
    .ir_enable(ir_enable), .addr_sel(addr_sel), .c_sel(c_sel),
    .operation(operation), .write_reg_enable(write_reg_enable),
    .flags_reg_enable(flags_reg_enable), .decoded_instruction(dec32),
    .illegal_instr(ill32), .zero_op(z32), .neg_op(n32),
    .unsigned_overflow(uo32), .signed_overflow(so32), .ram_addr(ra32),
    .data_out(do32), .data_in(din32));

  // Architectural model of the 16-bit instance
  logic [15:0] mreg [4];
  logic [3:0]  mflags;

  typedef struct {
    logic [7:0]  opc;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [3:0]  fl;
  } vec_t;
  vec_t vt [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    branch = 1'b0; pc_enable = 1'b0; ir_enable = 1'b0; addr_sel = 1'b0;
    c_sel = 1'b0; operation = 3'd0; write_reg_enable = 1'b0; flags_reg_enable = 1'b0;
  endtask

  // Returns {result, zero, neg, unsigned_ov, signed_ov} using integer arithmetic
  function automatic logic [19:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                          input logic [2:0] op);
    int ua, ub, sa, sb, r, s;
    logic [15:0] res;
    logic uo, so;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    uo = 1'b0; so = 1'b0;
    case (op)
      3'd0: res = a | b;
      3'd1: begin
        r = ua + ub; s = sa + sb;
        res = 16'(r); uo = (r > 65535); so = (s > 32767) || (s < -32768);
      end
      3'd2: begin
        r = ua - ub; s = sa - sb;
        res = 16'(r); uo = (ua < ub); so = (s > 32767) || (s < -32768);
      end
      3'd3: res = a & b;
      3'd4: res = a ^ b;
      default: res = a;
    endcase
    return {res, (res == 16'd0), res[15], uo, so};
  endfunction

  function automatic instr_t exp_dec(input logic [7:0] o);
    case (o)
      8'h81: return I_LOAD;   8'h82: return I_STORE;  8'h91: return I_MOVE;
      8'hA1: return I_ADD;    8'hA2: return I_SUB;    8'hA3: return I_AND;
      8'hA4: return I_OR;     8'hA5: return I_XOR;    8'h01: return I_BRANCH;
      8'h02: return I_BZERO;  8'h03: return I_BNEG;   8'h05: return I_BOV;
      8'h06: return I_BNOV;   8'h0A: return I_BNNEG;  8'h0B: return I_BNZERO;
      8'hFF: return I_HALT;
      default: return I_NOP;
    endcase
  endfunction

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic set_ir16(input logic [15:0] v);
    idle();
    din16 = v; ir_enable = 1'b1;
    step();
    idle();
  endtask

  task automatic do_load16(input int k, input int addr, input logic [15:0] val);
    set_ir16(16'(32'h8100 | (k << 5) | addr));
    din16 = val; addr_sel = 1'b1; c_sel = 1'b0; write_reg_enable = 1'b1;
    #1;
    chk("load_decode", 32'(dec16), 32'(I_LOAD));
    chk("load_ram_addr", 32'(ra16), 32'(addr));
    step();
    mreg[k] = val;
    idle();
  endtask

  task automatic store_check16(input int k, input string name);
    set_ir16(16'(32'h8200 | (k << 5)));
    chk(name, 32'(do16), 32'(mreg[k]));
  endtask

  task automatic alu16(input logic [7:0] opc, input logic [2:0] op, input int fa,
                       input int fb, input int fc, input logic fen);
    logic [19:0] r;
    set_ir16({opc, 8'(fc << 4 | fb << 2 | fa)});
    operation = op; c_sel = 1'b1; write_reg_enable = 1'b1; flags_reg_enable = fen;
    r = alu_ref(mreg[fa], mreg[fb], op);
    step();
    mreg[fc] = r[19:4];
    if (fen) mflags = r[3:0];
    idle();
  endtask

  initial begin
    vt[0] = '{8'hA1, 3'd1, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101};
    vt[1] = '{8'hA2, 3'd2, 16'h0003, 16'h0005, 16'hFFFE, 4'b0110};
    vt[2] = '{8'hA2, 3'd2, 16'h0005, 16'h0005, 16'h0000, 4'b1000};
    vt[3] = '{8'hA5, 3'd4, 16'h00FF, 16'h0F0F, 16'h0FF0, 4'b0000};
    vt[4] = '{8'hA1, 3'd1, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010};
    vt[5] = '{8'hA2, 3'd2, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001};
    vt[6] = '{8'hA3, 3'd3, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000};
    vt[7] = '{8'hA4, 3'd0, 16'h1200, 16'h0034, 16'h1234, 4'b0000};

    idle();
    din16 = '0; din32 = '0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    for (int i = 0; i < 4; i++) mreg[i] = '0;
    mflags = '0;

    // Reset state and first PC increment
    chk("rst_ram_addr", 32'(ra16), 32'd0);
    chk("rst_decode", 32'(dec16), 32'(I_NOP));
    chk("rst_illegal", 32'(ill16), 32'd0);
    chk("rst_flags", 32'({z16, n16, uo16, so16}), 32'd0);
    chk("rst_data_out", 32'(do16), 32'd0);
    pc_enable = 1'b1;
    step();
    idle();
    chk("pc_incr", 32'(ra16), 32'd1);

    // Decode of illegal and HALT opcodes
    set_ir16(16'h7E00);
    chk("illegal_flag", 32'(ill16), 32'd1);
    chk("illegal_decode", 32'(dec16), 32'(I_NOP));
    set_ir16(16'hFF00);
    chk("halt_decode", 32'(dec16), 32'(I_HALT));
    chk("halt_illegal", 32'(ill16), 32'd0);

    // PC branch to 31, wrap on increment, branch to 0x13
    set_ir16(16'h011F);
    chk("branch_decode", 32'(dec16), 32'(exp_dec(8'h01)));
    branch = 1'b1; pc_enable = 1'b1;
    step();
    idle();
    chk("pc_branch31", 32'(ra16), 32'd31);
    pc_enable = 1'b1;
    step();
    idle();
    chk("pc_wrap", 32'(ra16), 32'd0);
    addr_sel = 1'b1;
    #1;
    chk("ram_addr_mem", 32'(ra16), 32'd31);
    set_ir16(16'h0113);
    branch = 1'b1; pc_enable = 1'b1;
    step();
    idle();
    chk("pc_branch13", 32'(ra16), 32'h13);

    // ALU vector table
    for (int i = 0; i < 8; i++) begin
      do_load16(0, i, vt[i].a);
      do_load16(1, i + 8, vt[i].b);
      alu16(vt[i].opc, vt[i].op, 0, 1, 2, 1'b1);
      chk("vec_decode", 32'(dec16), 32'(exp_dec(vt[i].opc)));
      chk("vec_flags", 32'({z16, n16, uo16, so16}), 32'(vt[i].fl));
      store_check16(2, "vec_result");
      chk("vec_result_tbl", 32'(do16), 32'(vt[i].res));
    end

    // Read during same-cycle write returns the old value (MOVE R0 -> R0 through ADD)
    do_load16(0, 3, 16'h1234);
    set_ir16(16'h9100);
    operation = 3'd1; c_sel = 1'b1; write_reg_enable = 1'b1;
    #1;
    chk("rdw_old", 32'(do16), 32'h1234);
    step();
    idle();
    mreg[0] = 16'h2468;
    chk("rdw_new", 32'(do16), 32'h2468);

    // IR load together with register write: write follows the old IR
    do_load16(0, 1, 16'd5);
    do_load16(1, 2, 16'd7);
    set_ir16(16'hA124);
    din16 = 16'h8240; ir_enable = 1'b1;
    operation = 3'd1; c_sel = 1'b1; write_reg_enable = 1'b1;
    step();
    idle();
    mreg[2] = 16'd12;
    chk("ir_wr_same_cycle", 32'(do16), 32'd12);
    store_check16(0, "ir_wr_r0_kept");

    // Randomized ALU traffic with random flag loads
    for (int i = 0; i < 40; i++) begin
      int fa, fb, fc;
      logic [2:0] op;
      logic [7:0] opc;
      logic fen;
      fa = $urandom_range(0, 3);
      fb = $urandom_range(0, 3);
      fc = $urandom_range(0, 3);
      op = 3'($urandom_range(0, 7));
      opc = 8'(8'hA1 + $urandom_range(0, 4));
      fen = 1'($urandom_range(0, 1));
      do_load16(fa, $urandom_range(0, 31), rnd16());
      do_load16(fb, $urandom_range(0, 31), rnd16());
      alu16(opc, op, fa, fb, fc, fen);
      chk("rand_flags", 32'({z16, n16, uo16, so16}), 32'(mflags));
      store_check16(fc, "rand_result");
    end

    // 32-bit, 8-register instance: LOAD R7 from 0xA5, STORE it back
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    begin
      logic [31:0] word;
      word = $urandom;
      din32 = 32'h8100_07A5; ir_enable = 1'b1;
      step();
      idle();
      din32 = word; addr_sel = 1'b1; c_sel = 1'b0; write_reg_enable = 1'b1;
      #1;
      chk("w32_load_addr", 32'(ra32), 32'hA5);
      chk("w32_load_decode", 32'(dec32), 32'(I_LOAD));
      step();
      idle();
      din32 = 32'h8200_07A5; ir_enable = 1'b1;
      step();
      idle();
      chk("w32_store_data", do32, word);
      chk("w32_store_addr_pc", 32'(ra32), 32'd0);
    end

    // Reset mid-instruction: ADD R7+R7 -> R7 pending, rst asserted between edges
    din32 = 32'hA100_01FF; ir_enable = 1'b1;
    step();
    idle();
    operation = 3'd1; c_sel = 1'b1; write_reg_enable = 1'b1;
    flags_reg_enable = 1'b1; addr_sel = 1'b1; pc_enable = 1'b1;
    #2;
    chk("w32_pre_rst_decode", 32'(dec32), 32'(I_ADD));
    rst = 1'b1;
    #1;
    chk("w32_rst_decode", 32'(dec32), 32'(I_NOP));
    chk("w32_rst_ram_addr", 32'(ra32), 32'd0);
    chk("w32_rst_illegal", 32'(ill32), 32'd0);
    step();
    rst = 1'b0;
    idle();
    step();
    chk("w32_rst_flags", 32'({z32, n32, uo32, so32}), 32'd0);
    din32 = 32'h8200_0700; ir_enable = 1'b1;
    step();
    idle();
    chk("w32_rst_r7", do32, 32'd0);
    chk("w32_rst_pc", 32'(ra32), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
